spike_rate_meter: RTL and testbench

SPIKE_RATE_METER -- requirements
Module: spike_rate_meter

---
 rtl/spike_rate_meter.sv | 115 +++++++++++
 tb/tb_spike_rate_meter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_meter.sv
// Windowed spike-rate meter: counts spikes and tracks peak membrane potential
// over a programmable window, flags bursts and measures inter-spike intervals.
module spike_rate_meter #(
  parameter int CNT_W = 8,
  parameter int U_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike,
  input  logic [U_W-1:0]   u_in,
  input  logic [2:0]       win_len,
  input  logic [CNT_W-1:0] burst_thr,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic [U_W-1:0]   peak_u,
  output logic             burst,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid
);

  localparam int WIN_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state;
  logic [2:0]       wl_reg;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spike_cnt;
  logic [CNT_W-1:0] isi_cnt;
  logic [U_W-1:0]   peak_acc;
  logic             seen_spike;

  logic [2:0]       wl_eff;
  logic [11:0]      win_last;
  logic             win_at_last;
  logic [CNT_W-1:0] spike_cnt_next;
  logic [CNT_W-1:0] isi_cnt_next;
  logic [U_W-1:0]   peak_next;

  // The first enabled edge out of IDLE is already window cycle 0, so it
  // must use win_len directly rather than the not-yet-latched copy.
  always_comb begin
    wl_eff         = (state == IDLE) ? win_len : wl_reg;
    win_last       = (12'd16 << wl_eff) - 12'd1;
    win_at_last    = ({1'b0, win_cnt} == win_last);
    spike_cnt_next = (spike && (spike_cnt != CNT_MAX)) ? spike_cnt + CNT_ONE : spike_cnt;
    isi_cnt_next   = (isi_cnt != CNT_MAX) ? isi_cnt + CNT_ONE : isi_cnt;
    peak_next      = (u_in > peak_acc) ? u_in : peak_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wl_reg     <= 3'd0;
      win_cnt    <= '0;
      spike_cnt  <= '0;
      isi_cnt    <= '0;
      peak_acc   <= '0;
      seen_spike <= 1'b0;
      rate       <= '0;
      rate_valid <= 1'b0;
      peak_u     <= '0;
      burst      <= 1'b0;
      isi        <= '0;
      isi_valid  <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
      if (ena) begin
        state <= COUNT;
        if (state == IDLE) begin
          wl_reg <= win_len;
        end
        if (win_at_last) begin
          rate       <= spike_cnt_next;
          peak_u     <= peak_next;
          burst      <= (spike_cnt_next >= burst_thr);
          rate_valid <= 1'b1;
          spike_cnt  <= '0;
          peak_acc   <= '0;
          win_cnt    <= '0;
          wl_reg     <= win_len;
        end else begin
          spike_cnt  <= spike_cnt_next;
          peak_acc   <= peak_next;
          win_cnt    <= win_cnt + WIN_ONE;
        end
        // isi_cnt holds cycles since the last spike minus one.
        if (spike) begin
          isi_cnt    <= '0;
          seen_spike <= 1'b1;
          if (seen_spike) begin
            isi       <= isi_cnt_next;
            isi_valid <= 1'b1;
          end
        end else begin
          isi_cnt <= isi_cnt_next;
        end
      end else begin
        // Leaving COUNT discards any partial window.
        state      <= IDLE;
        win_cnt    <= '0;
        spike_cnt  <= '0;
        isi_cnt    <= '0;
        peak_acc   <= '0;
        seen_spike <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_meter.sv
// Directed bench for spike_rate_meter; a second instance with CNT_W=4
// covers count and interval saturation.
module tb_spike_rate_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       spike = 1'b0;
  logic [3:0] u_in = 4'd0;
  logic [2:0] win_len = 3'd0;
  logic [7:0] burst_thr = 8'd4;

  logic [7:0] rate, isi;
  logic       rate_valid, burst, isi_valid;
  logic [3:0] peak_u;

  logic [3:0] rate4, isi4, peak_u4;
  logic       rate_valid4, burst4, isi_valid4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spike_rate_meter #(.CNT_W(8), .U_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike), .u_in(u_in),
    .win_len(win_len), .burst_thr(burst_thr), .rate(rate),
    .rate_valid(rate_valid), .peak_u(peak_u), .burst(burst), .isi(isi),
    .isi_valid(isi_valid)
  );

  spike_rate_meter #(.CNT_W(4), .U_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike), .u_in(u_in),
    .win_len(win_len), .burst_thr(burst_thr[3:0]), .rate(rate4),
    .rate_valid(rate_valid4), .peak_u(peak_u4), .burst(burst4), .isi(isi4),
    .isi_valid(isi_valid4)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    ena   = 1'b0;
    spike = 1'b0;
    u_in  = 4'd0;
    step();
  endtask

  int pulses, ipulses, idx0, idx1;
  int rate0, rate1, peak0, peak1, burst0, burst1;

  initial begin
    #2;
    check("reset_rate", int'(rate), 0);
    check("reset_rate_valid", int'(rate_valid), 0);
    check("reset_peak", int'(peak_u), 0);
    check("reset_isi", int'(isi), 0);
    check("reset_isi_valid", int'(isi_valid), 0);
    step();
    step();
    rst_n = 1'b1;

    // spikes every 4th cycle, two 16-cycle windows
    pulses = 0; idx0 = -1; idx1 = -1;
    for (int i = 0; i < 32; i++) begin
      ena = 1'b1; spike = (i % 4 == 0); u_in = 4'd0;
      step();
      if (rate_valid) begin
        if (pulses == 0) begin idx0 = i; rate0 = int'(rate); burst0 = int'(burst); end
        else begin idx1 = i; rate1 = int'(rate); burst1 = int'(burst); end
        pulses++;
      end
    end
    check("t1_pulses", pulses, 2);
    check("t1_idx0", idx0, 15);
    check("t1_idx1", idx1, 31);
    check("t1_rate0", rate0, 4);
    check("t1_rate1", rate1, 4);
    check("t1_burst0", burst0, 1);
    check("t1_burst1", burst1, 1);
    check("t1_isi", int'(isi), 4);
    go_idle();

    // spike held high for a full window
    pulses = 0; ipulses = 0;
    for (int i = 0; i < 16; i++) begin
      ena = 1'b1; spike = 1'b1;
      step();
      if (rate_valid) pulses++;
      if (isi_valid) ipulses++;
    end
    check("t2_pulses", pulses, 1);
    check("t2_isi_pulses", ipulses, 15);
    check("t2_rate", int'(rate), 16);
    check("t2_isi", int'(isi), 1);
    check("t2_rate_sat4", int'(rate4), 15);
    check("t2_burst4", int'(burst4), 1);
    go_idle();

    // peak tracking over two windows
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      ena = 1'b1; spike = 1'b0;
      case (i)
        0: u_in = 4'd2;
        1: u_in = 4'd9;
        2: u_in = 4'd5;
        16: u_in = 4'd0;
        17: u_in = 4'd1;
        18: u_in = 4'd2;
        19: u_in = 4'd3;
        default: u_in = 4'd0;
      endcase
      step();
      if (rate_valid) begin
        if (pulses == 0) begin peak0 = int'(peak_u); burst0 = int'(burst); end
        else peak1 = int'(peak_u);
        pulses++;
      end
    end
    check("t3_pulses", pulses, 2);
    check("t3_peak0", peak0, 9);
    check("t3_peak1", peak1, 3);
    check("t3_burst0", burst0, 0);
    go_idle();

    // long interval saturates
    ipulses = 0;
    for (int i = 0; i < 310; i++) begin
      ena = 1'b1; spike = (i == 3 || i == 303);
      step();
      if (isi_valid) ipulses++;
    end
    check("t4_isi_pulses", ipulses, 1);
    check("t4_isi_sat", int'(isi), 255);
    check("t4_isi_sat4", int'(isi4), 15);
    go_idle();

    ipulses = 0;
    for (int i = 0; i < 21; i++) begin
      ena = 1'b1; spike = (i == 10 || i == 17);
      step();
      if (isi_valid) ipulses++;
    end
    check("t4b_isi_pulses", ipulses, 1);
    check("t4b_isi", int'(isi), 7);
    go_idle();

    // partial window discard, then win_len change inside a window
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      ena = 1'b1; spike = (i < 5);
      step();
      if (rate_valid) pulses++;
    end
    check("t5_rate_full", int'(rate), 5);
    for (int i = 0; i < 10; i++) begin
      ena = 1'b1; spike = 1'b1;
      step();
      if (rate_valid) pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      ena = 1'b0; spike = 1'b0;
      step();
      if (rate_valid) pulses++;
    end
    check("t5_partial_pulses", pulses, 1);
    check("t5_rate_kept", int'(rate), 5);
    check("t5_burst_kept", int'(burst), 1);

    win_len = 3'd1;
    pulses = 0; idx0 = -1; idx1 = -1;
    for (int i = 0; i < 48; i++) begin
      ena = 1'b1; spike = (i < 3);
      if (i == 5) win_len = 3'd0;
      step();
      if (rate_valid) begin
        if (pulses == 0) begin idx0 = i; rate0 = int'(rate); burst0 = int'(burst); end
        else begin idx1 = i; rate1 = int'(rate); end
        pulses++;
      end
    end
    check("t5_win_pulses", pulses, 2);
    check("t5_idx0", idx0, 31);
    check("t5_idx1", idx1, 47);
    check("t5_rate0", rate0, 3);
    check("t5_burst0", burst0, 0);
    check("t5_rate1", rate1, 0);
    go_idle();

    // asynchronous reset mid-window
    for (int i = 0; i < 24; i++) begin
      ena = 1'b1; spike = 1'b1; u_in = 4'd7;
      step();
    end
    check("t6_pre_rate", int'(rate), 16);
    check("t6_pre_peak", int'(peak_u), 7);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rate", int'(rate), 0);
    check("t6_rst_peak", int'(peak_u), 0);
    check("t6_rst_burst", int'(burst), 0);
    check("t6_rst_isi", int'(isi), 0);
    step();
    check("t6_rst_held_valid", int'(rate_valid), 0);
    rst_n = 1'b1;
    pulses = 0; idx0 = -1;
    for (int i = 0; i < 16; i++) begin
      ena = 1'b1; spike = 1'b1; u_in = 4'd0;
      step();
      if (rate_valid) begin
        pulses++; idx0 = i; rate0 = int'(rate);
      end
    end
    check("t6_post_pulses", pulses, 1);
    check("t6_post_idx", idx0, 15);
    check("t6_post_rate", rate0, 16);
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
